// File: rtl/ppbuf_pkg.sv
// Shared definitions for the ping-pong buffer: FSM state encoding and bank-select constants.
package ppbuf_pkg;

  typedef logic [1:0] ppbuf_state_t;

  localparam ppbuf_state_t ST_IDLE = 2'd0;
  localparam ppbuf_state_t ST_RUN  = 2'd1;
  localparam ppbuf_state_t ST_DONE = 2'd2;
  localparam ppbuf_state_t ST_SWAP = 2'd3;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  function automatic logic host_allowed(input ppbuf_state_t st, input logic pingpong);
    host_allowed = (st != ST_SWAP) && !((st == ST_RUN) && !pingpong);
  endfunction

endpackage

// File: rtl/ppbuf_bank.sv
// One synchronous single-port RAM bank with per-byte write enables.
// Contents are deliberately not reset; read data is registered one cycle after a read.
module ppbuf_bank
  import ppbuf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/pingpong_buf_wrapper.sv
// Ping-pong (or single shared) buffer between a host port and an EPU port with job/swap FSM.
// Define PPBUF_WSTRB_EN to make host writes honour h_wstrb_i; otherwise host writes are full-word.
module pingpong_buf_wrapper
  import ppbuf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int PINGPONG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                finish_i,
  input  logic                swap_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                sel_o,
  input  logic                h_req_i,
  input  logic                h_we_i,
  input  logic [ADDR_W-1:0]   h_addr_i,
  input  logic [DATA_W-1:0]   h_wdata_i,
  input  logic [DATA_W/8-1:0] h_wstrb_i,
  output logic                h_gnt_o,
  output logic                h_rvalid_o,
  output logic [DATA_W-1:0]   h_rdata_o,
  input  logic                e_cs_i,
  input  logic                e_oe_i,
  input  logic                e_we_i,
  input  logic [ADDR_W-1:0]   e_addr_i,
  input  logic [DATA_W-1:0]   e_wdata_i,
  output logic [DATA_W-1:0]   e_rdata_o
);

  localparam int  STRB_W = DATA_W / 8;
  localparam logic PP    = (PINGPONG != 0);
  localparam int  NB     = PP ? 2 : 1;

  ppbuf_state_t state, state_nxt;
  logic         pending, pending_nxt;
  logic         sel;
  logic         swap_ok;
  logic         run;
  logic         host_bank, epu_bank;
  logic [STRB_W-1:0] host_be;
  logic         h_rd_q, h_bank_q;
  logic         e_rd_q, e_bank_q;
  logic [DATA_W-1:0] bk_rdata [2];

`ifdef PPBUF_WSTRB_EN
  assign host_be = h_wstrb_i;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^h_wstrb_i;
  assign host_be      = '1;
`endif

  assign swap_ok   = swap_i && PP;
  assign run       = (state == ST_RUN);
  assign host_bank = PP ? ~sel : BANK0;
  assign epu_bank  = PP ? sel : BANK0;

  // A swap requested while the EPU is busy (or while starting) is remembered once and
  // serviced right after the completion pulse.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_RUN;
          if (swap_ok) pending_nxt = 1'b1;
        end else if (swap_ok) begin
          state_nxt = ST_SWAP;
        end
      end
      ST_RUN: begin
        if (swap_ok) pending_nxt = 1'b1;
        if (finish_i) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = (pending || swap_ok) ? ST_SWAP : ST_IDLE;
      ST_SWAP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if ((state_nxt == ST_SWAP) && (state != ST_SWAP)) pending_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      sel     <= BANK0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (state == ST_SWAP) sel <= ~sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_rd_q   <= 1'b0;
      h_bank_q <= BANK0;
      e_rd_q   <= 1'b0;
      e_bank_q <= BANK0;
    end else begin
      h_rd_q   <= h_gnt_o && !h_we_i;
      h_bank_q <= host_bank;
      e_rd_q   <= run && e_cs_i && e_oe_i && !e_we_i;
      e_bank_q <= epu_bank;
    end
  end

  assign busy_o     = run;
  assign done_o     = (state == ST_DONE);
  assign sel_o      = sel;
  assign h_gnt_o    = h_req_i && host_allowed(state, PP);
  assign h_rvalid_o = h_rd_q;
  assign h_rdata_o  = h_rd_q ? bk_rdata[h_bank_q] : '0;
  assign e_rdata_o  = (e_rd_q && run) ? bk_rdata[e_bank_q] : '0;

  // Host and EPU always resolve to different banks whenever both are active, so each
  // bank simply takes whichever side currently targets it.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    localparam logic BIDX = (b == 1);
    logic              e_hit, h_hit;
    logic              bk_en, bk_we;
    logic [STRB_W-1:0] bk_be;
    logic [ADDR_W-1:0] bk_addr;
    logic [DATA_W-1:0] bk_wdata;

    assign e_hit    = run && e_cs_i && (e_we_i || e_oe_i) && (epu_bank == BIDX);
    assign h_hit    = h_gnt_o && (host_bank == BIDX);
    assign bk_en    = e_hit || h_hit;
    assign bk_we    = e_hit ? e_we_i : h_we_i;
    assign bk_be    = e_hit ? {STRB_W{1'b1}} : host_be;
    assign bk_addr  = e_hit ? e_addr_i : h_addr_i;
    assign bk_wdata = e_hit ? e_wdata_i : h_wdata_i;

    ppbuf_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .en    (bk_en),
      .we    (bk_we),
      .be    (bk_be),
      .addr  (bk_addr),
      .wdata (bk_wdata),
      .rdata (bk_rdata[b])
    );
  end

  if (NB == 1) begin : g_tie
    assign bk_rdata[1] = '0;
  end

endmodule

// File: tb/tb_pingpong_buf_wrapper.sv
// Directed self-checking bench: one ping-pong instance and one single-bank instance.
module tb_pingpong_buf_wrapper;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  logic          a_start, a_finish, a_swap, a_busy, a_done, a_sel;
  logic          a_h_req, a_h_we, a_h_gnt, a_h_rvalid;
  logic [AW-1:0] a_h_addr, a_e_addr;
  logic [DW-1:0] a_h_wdata, a_h_rdata, a_e_wdata, a_e_rdata;
  logic [SW-1:0] a_h_wstrb;
  logic          a_e_cs, a_e_oe, a_e_we;

  logic          b_start, b_finish, b_swap, b_busy, b_done, b_sel;
  logic          b_h_req, b_h_we, b_h_gnt, b_h_rvalid;
  logic [AW-1:0] b_h_addr, b_e_addr;
  logic [DW-1:0] b_h_wdata, b_h_rdata, b_e_wdata, b_e_rdata;
  logic [SW-1:0] b_h_wstrb;
  logic          b_e_cs, b_e_oe, b_e_we;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pingpong_buf_wrapper #(.DATA_W(DW), .ADDR_W(AW), .PINGPONG(1)) u_pp (
    .clk(clk), .rst(rst), .start_i(a_start), .finish_i(a_finish), .swap_i(a_swap),
    .busy_o(a_busy), .done_o(a_done), .sel_o(a_sel),
    .h_req_i(a_h_req), .h_we_i(a_h_we), .h_addr_i(a_h_addr), .h_wdata_i(a_h_wdata),
    .h_wstrb_i(a_h_wstrb), .h_gnt_o(a_h_gnt), .h_rvalid_o(a_h_rvalid), .h_rdata_o(a_h_rdata),
    .e_cs_i(a_e_cs), .e_oe_i(a_e_oe), .e_we_i(a_e_we), .e_addr_i(a_e_addr),
    .e_wdata_i(a_e_wdata), .e_rdata_o(a_e_rdata)
  );

  pingpong_buf_wrapper #(.DATA_W(DW), .ADDR_W(AW), .PINGPONG(0)) u_sp (
    .clk(clk), .rst(rst), .start_i(b_start), .finish_i(b_finish), .swap_i(b_swap),
    .busy_o(b_busy), .done_o(b_done), .sel_o(b_sel),
    .h_req_i(b_h_req), .h_we_i(b_h_we), .h_addr_i(b_h_addr), .h_wdata_i(b_h_wdata),
    .h_wstrb_i(b_h_wstrb), .h_gnt_o(b_h_gnt), .h_rvalid_o(b_h_rvalid), .h_rdata_o(b_h_rdata),
    .e_cs_i(b_e_cs), .e_oe_i(b_e_oe), .e_we_i(b_e_we), .e_addr_i(b_e_addr),
    .e_wdata_i(b_e_wdata), .e_rdata_o(b_e_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cs, input logic oe, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    a_e_cs    = cs;
    a_e_oe    = oe;
    a_e_we    = we;
    a_e_addr  = addr;
    a_e_wdata = wdata;
  endtask

  task automatic a_host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] strb);
    a_h_req   = 1'b1;
    a_h_we    = 1'b1;
    a_h_addr  = addr;
    a_h_wdata = data;
    a_h_wstrb = strb;
    #1;
    checkOutput("a_wr_gnt", 32'(a_h_gnt), 32'd1);
    tick();
    a_h_req = 1'b0;
    a_h_we  = 1'b0;
  endtask

  task automatic a_host_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    a_h_req  = 1'b1;
    a_h_we   = 1'b0;
    a_h_addr = addr;
    #1;
    checkOutput("a_rd_gnt", 32'(a_h_gnt), 32'd1);
    tick();
    a_h_req = 1'b0;
    checkOutput("a_rvalid", 32'(a_h_rvalid), 32'd1);
    checkOutput(tag, a_h_rdata, exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] strb_exp;
    rst = 1'b1;
    a_start = 0; a_finish = 0; a_swap = 0; a_h_req = 0; a_h_we = 0;
    a_h_addr = '0; a_h_wdata = '0; a_h_wstrb = '1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    b_start = 0; b_finish = 0; b_swap = 0; b_h_req = 0; b_h_we = 0;
    b_h_addr = '0; b_h_wdata = '0; b_h_wstrb = '1;
    b_e_cs = 0; b_e_oe = 0; b_e_we = 0; b_e_addr = '0; b_e_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(a_busy), 32'd0);
    checkOutput("rst_done", 32'(a_done), 32'd0);
    checkOutput("rst_sel", 32'(a_sel), 32'd0);
    checkOutput("rst_rvalid", 32'(a_h_rvalid), 32'd0);
    checkOutput("rst_hrdata", a_h_rdata, 32'd0);
    checkOutput("rst_erdata", a_e_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Basic host write then read (bank 1 while sel = 0)
    a_host_write(8'd5, 32'hDEADBEEF, 4'hF);
    a_host_read("a_rd5", 8'd5, 32'hDEADBEEF);
    tick();
    checkOutput("a_rvalid_drop", 32'(a_h_rvalid), 32'd0);
    checkOutput("a_rdata_zero", a_h_rdata, 32'd0);

    // Fill bank 1, then swap it to the EPU
    a_host_write(8'd0, 32'h00000011, 4'hF);
    a_host_write(8'd10, 32'h00001010, 4'hF);
    a_swap = 1'b1;
    tick();
    a_swap  = 1'b0;
    a_h_req = 1'b1;
    a_h_we  = 1'b0;
    a_h_addr = 8'd0;
    #1;
    checkOutput("a_swap_gnt", 32'(a_h_gnt), 32'd0);
    tick();
    a_h_req = 1'b0;
    checkOutput("a_sel_after_swap", 32'(a_sel), 32'd1);
    checkOutput("a_swap_no_rvalid", 32'(a_h_rvalid), 32'd0);

    // EPU accesses outside RUN are inert
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd10, 32'h00000BAD);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, '0);
    tick();
    checkOutput("a_erdata_idle", a_e_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checkOutput("a_busy_run", 32'(a_busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, '0);
    tick();
    checkOutput("a_erd0", a_e_rdata, 32'h00000011);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, '0);
    a_host_write(8'd3, 32'h000000A5, 4'hF);
    checkOutput("a_erd5", a_e_rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd9, 32'h00000099);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    // Two swap requests during RUN collapse into one swap after DONE
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    tick();
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    checkOutput("a_busy_still", 32'(a_busy), 32'd1);
    a_finish = 1'b1;
    tick();
    a_finish = 1'b0;
    checkOutput("a_done_pulse", 32'(a_done), 32'd1);
    checkOutput("a_busy_done", 32'(a_busy), 32'd0);
    tick();
    checkOutput("a_done_gone", 32'(a_done), 32'd0);
    a_h_req  = 1'b1;
    a_h_we   = 1'b0;
    a_h_addr = 8'd0;
    #1;
    checkOutput("a_swap2_gnt", 32'(a_h_gnt), 32'd0);
    tick();
    a_h_req = 1'b0;
    checkOutput("a_sel_toggled", 32'(a_sel), 32'd0);
    tick();
    checkOutput("a_sel_once", 32'(a_sel), 32'd0);

    a_host_read("a_rd9_epu_wr", 8'd9, 32'h00000099);
    a_host_read("a_rd10_dropped", 8'd10, 32'h00001010);

    // Byte strobe behaviour depends on the build
    a_host_write(8'd12, 32'hFFFFFFFF, 4'hF);
    a_host_write(8'd12, 32'h00000000, 4'b0010);
`ifdef PPBUF_WSTRB_EN
    strb_exp = 32'hFFFF00FF;
`else
    strb_exp = 32'h00000000;
`endif
    a_host_read("a_wstrb", 8'd12, strb_exp);

    // Back-to-back host reads, one word per cycle
    a_h_req = 1'b1;
    a_h_we  = 1'b0;
    a_h_addr = 8'd5;
    tick();
    checkOutput("a_b2b_5", a_h_rdata, 32'hDEADBEEF);
    a_h_addr = 8'd9;
    tick();
    checkOutput("a_b2b_9", a_h_rdata, 32'h00000099);
    a_h_addr = 8'd10;
    tick();
    checkOutput("a_b2b_10", a_h_rdata, 32'h00001010);
    checkOutput("a_b2b_vld", 32'(a_h_rvalid), 32'd1);
    a_h_req = 1'b0;
    tick();
    checkOutput("a_b2b_end", 32'(a_h_rvalid), 32'd0);

    // Reset in the middle of a job with sel = 1
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    tick();
    checkOutput("a_sel_pre_rst", 32'(a_sel), 32'd1);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checkOutput("a_busy_pre_rst", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("a_rst_busy", 32'(a_busy), 32'd0);
    checkOutput("a_rst_sel", 32'(a_sel), 32'd0);
    checkOutput("a_rst_done", 32'(a_done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("a_post_rst_done", 32'(a_done), 32'd0);
    checkOutput("a_post_rst_busy", 32'(a_busy), 32'd0);
    a_host_read("a_rd5_post_rst", 8'd5, 32'hDEADBEEF);

    // Single shared bank
    b_h_req = 1'b1; b_h_we = 1'b1; b_h_addr = 8'd2; b_h_wdata = 32'h00000022;
    #1;
    checkOutput("b_wr_gnt", 32'(b_h_gnt), 32'd1);
    tick();
    b_h_req = 1'b0; b_h_we = 1'b0;
    b_swap = 1'b1;
    tick();
    b_swap = 1'b0;
    checkOutput("b_sel_fixed", 32'(b_sel), 32'd0);
    b_h_req = 1'b1;
    #1;
    checkOutput("b_no_swap_gnt", 32'(b_h_gnt), 32'd1);
    tick();
    b_h_req = 1'b0;
    checkOutput("b_rd2", b_h_rdata, 32'h00000022);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    checkOutput("b_busy", 32'(b_busy), 32'd1);
    b_h_req = 1'b1; b_h_we = 1'b1; b_h_addr = 8'd2; b_h_wdata = 32'h000000EE;
    #1;
    checkOutput("b_run_gnt", 32'(b_h_gnt), 32'd0);
    b_e_cs = 1'b1; b_e_oe = 1'b1; b_e_addr = 8'd2;
    tick();
    checkOutput("b_run_gnt2", 32'(b_h_gnt), 32'd0);
    checkOutput("b_erd2", b_e_rdata, 32'h00000022);
    b_e_cs = 1'b0; b_e_oe = 1'b0;
    b_h_req = 1'b0; b_h_we = 1'b0;
    b_finish = 1'b1;
    tick();
    b_finish = 1'b0;
    checkOutput("b_done", 32'(b_done), 32'd1);
    b_h_req = 1'b1; b_h_addr = 8'd2;
    #1;
    checkOutput("b_done_gnt", 32'(b_h_gnt), 32'd1);
    tick();
    b_h_req = 1'b0;
    checkOutput("b_rd2_after", b_h_rdata, 32'h00000022);
    checkOutput("b_idle_again", 32'(b_done), 32'd0);
    checkOutput("b_sel_end", 32'(b_sel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pingpong_buf_wrapper.md
PINGPONG_BUF_WRAPPER -- requirements
Module: pingpong_buf_wrapper

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, word width.
- ADDR_W, 16, word-address width per bank; bank depth is 2**ADDR_W.
- PINGPONG, 1, 1 = two banks with concurrent host/EPU access; 0 = one shared bank.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- start_i, in, 1, EPU job start.
- finish_i, in, 1, EPU job end.
- swap_i, in, 1, request bank-ownership swap.
- busy_o, out, 1, EPU job running.
- done_o, out, 1, one-cycle job-complete pulse.
- sel_o, out, 1, index of the EPU-owned bank.
- h_req_i, in, 1, host request.
- h_we_i, in, 1, host write.
- h_addr_i, in, ADDR_W, host word address.
- h_wdata_i, in, DATA_W, host write data.
- h_wstrb_i, in, DATA_W/8, host byte strobes.
- h_gnt_o, out, 1, host grant.
- h_rvalid_o, out, 1, host read data valid.
- h_rdata_o, out, DATA_W, host read data.
- e_cs_i, in, 1, EPU chip select.
- e_oe_i, in, 1, EPU output enable.
- e_we_i, in, 1, EPU write.
- e_addr_i, in, ADDR_W, EPU word address.
- e_wdata_i, in, DATA_W, EPU write data.
- e_rdata_o, out, DATA_W, EPU read data.
REQ-003 The design SHALL use one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, RUN, DONE, SWAP.
- IDLE: start_i -> RUN; else swap_i -> SWAP (PINGPONG=1 only).
- RUN: finish_i -> DONE.
- DONE: lasts 1 cycle; goes to SWAP if a swap is pending, else IDLE.
- SWAP: lasts 1 cycle, then IDLE; sel toggles on exit.
REQ-005 busy_o SHALL be high in RUN; done_o SHALL be high exactly in DONE.
REQ-006 If swap_i arrives in RUN, DONE, or together with start_i in IDLE, a single pending flag SHALL be set; repeated swap_i SHALL NOT stack.
- The pending flag clears when SWAP is entered.
REQ-007 In PINGPONG=0, swap_i SHALL be ignored and sel_o SHALL stay 0.
REQ-008 EPU accesses SHALL target bank sel and take effect only in RUN.
- Outside RUN, e_rdata_o = 0 and EPU writes are dropped.
REQ-009 EPU read: when e_cs_i & e_oe_i & !e_we_i, e_rdata_o SHALL present mem[e_addr_i] one cycle later (synchronous SRAM).
REQ-010 EPU write: when e_cs_i & e_we_i, a full-word write SHALL occur at the clock edge.
REQ-011 h_gnt_o SHALL be combinational: h_req_i & host_ok.
- host_ok is 0 in SWAP.
- host_ok is 0 in RUN when PINGPONG=0.
- Otherwise host_ok is 1.
REQ-012 Host accesses SHALL target bank !sel (PINGPONG=1) or bank 0 (PINGPONG=0).
REQ-013 A granted host read SHALL raise h_rvalid_o for exactly one cycle, one cycle after grant, carrying h_rdata_o; h_rdata_o SHALL be 0 when h_rvalid_o is low.
REQ-014 Back-to-back granted host reads SHALL sustain one word per cycle.
REQ-015 A granted host write SHALL update the bytes enabled by h_wstrb_i (see REQ-020).
REQ-016 Host and EPU SHALL never access the same bank in the same cycle.
- A host request not granted SHALL have no side effect.

Reset
REQ-017 On rst, the following SHALL be forced immediately: state = IDLE, sel = 0, pending = 0, busy_o = 0, done_o = 0, h_rvalid_o = 0, h_rdata_o = 0, e_rdata_o = 0.
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 Reset during RUN or SWAP SHALL abort the operation with no completion pulse.

Configuration
REQ-020 Macro PPBUF_WSTRB_EN:
- Defined: host writes honour h_wstrb_i per byte.
- Undefined: h_wstrb_i is ignored and every granted host write is a full-word write.

Structure
REQ-021 A shared package ppbuf_pkg SHALL hold the FSM state enum and the bank-select constants.
REQ-022 A single sub-module ppbuf_bank SHALL implement one synchronous single-port RAM with byte-enable write.
- It is parameterised by DATA_W and ADDR_W.
- It is instantiated 1 + PINGPONG times.

Verification
REQ-023 Host write 0xDEADBEEF to addr 5 in IDLE, then host read addr 5 -> gnt same cycle; rvalid one cycle later with data 0xDEADBEEF.
REQ-024 Swap path (PINGPONG=1):
- Host fills bank 1 addr 0 = 0x11.
- swap_i in IDLE -> SWAP for one cycle with gnt=0, then sel_o=1.
- start_i; EPU reads addr 0 -> e_rdata_o = 0x11.
REQ-025 swap_i pulsed twice during RUN, then finish_i -> done_o one cycle, then SWAP, sel toggles exactly once.
REQ-026 PINGPONG=0 with h_req_i held during RUN -> h_gnt_o = 0 until DONE; no memory change.
REQ-027 With PPBUF_WSTRB_EN: word = 0xFFFFFFFF, write 0x00000000 with strobe 4'b0010 -> readback 0xFFFF00FF; without the macro -> readback 0x00000000.
REQ-028 Assert rst mid-RUN after sel=1 -> next cycle busy_o = 0, sel_o = 0, no done_o; previously written data still readable.
